win3x3_frame_arb: RTL and testbench
===================================

WIN3X3_FRAME_ARB -- requirements
Module: win3x3_frame_arb

Interface
REQ-001 Parameter H_DISP, default 12'd480: active pixels per line.
REQ-002 Parameter V_DISP, default 12'd272: active lines per frame.
REQ-003 clk  input  1  clock; all logic on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 s0_vld  input  1  source 0 pixel valid.
REQ-006 s0_sof  input  1  source 0 start-of-frame; qualifies pixel (0,0).
REQ-007 s0_data  input  8  source 0 pixel.
REQ-008 s0_rdy  output  1  source 0 ready; a pixel transfers when s0_vld && s0_rdy.
REQ-009 s1_vld, s1_sof, s1_data, s1_rdy  in/in/in/out  1/1/8/1  source 1, same meaning as source 0.
REQ-010 m_din_vld  output  1  pixel valid to the shared 3x3 window core.
REQ-011 m_din  output  8  pixel to the shared 3x3 window core.
REQ-012 o_vld  output  1  window output valid, aligned to the core's 1-clk latency.
REQ-013 o_ch  output  1  source index of the window now on the core outputs.
REQ-014 o_x, o_y  output  12 each  column/row of the pixel that produced the current window.
REQ-015 o_eof  output  1  single-cycle pulse with the last window of a frame.
REQ-016 busy  output  1  high while a frame is granted.
REQ-017 err_sof  output  1  sticky flag: SOF seen mid-frame on the granted source.

Function
REQ-018 FSM states: IDLE, GNT0, GNT1; reset state IDLE.
REQ-019 A request is sN_vld && sN_sof; it is evaluated only in IDLE.
REQ-020 IDLE with a single request moves to GNTN on the next clock.
REQ-021 IDLE with both requests grants the source not served last, using a round-robin pointer that resets to favour source 0.
REQ-022 The round-robin pointer updates only on frame completion.
REQ-023 In GNTN, sN_rdy = 1 combinationally; the other source's rdy = 0.
REQ-024 m_din_vld = sN_vld in GNTN and 0 in IDLE; m_din = sN_data in GNTN and 8'd0 in IDLE; both are combinational.
REQ-025 In IDLE, sN_rdy = sN_vld && !sN_sof: stray non-SOF pixels are accepted and discarded, never forwarded.
REQ-026 In IDLE, SOF pixels are held (rdy=0) until granted.
REQ-027 The column counter x (0..H_DISP-1) advances on each transferred pixel in GNTN and wraps to 0 at H_DISP-1.
REQ-028 The row counter y advances when x wraps.
REQ-029 Both counters are 0 on entry to GNTN.
REQ-030 A transfer at x==H_DISP-1 and y==V_DISP-1 completes the frame: the state returns to IDLE on the next clock, counters clear, and the pointer records N.
REQ-031 The minimum gap between frames is 1 IDLE cycle; no grant is issued in the completing cycle.
REQ-032 sN_sof on a granted transfer with (x,y) != (0,0) sets err_sof. The pixel is forwarded and counted normally; the frame is not restarted.
REQ-033 err_sof clears only on reset.
REQ-034 The registered outputs o_vld, o_ch, o_x, o_y and o_eof take, one clock after a transfer, m_din_vld, the granted index, the pre-increment x and y, and the last-pixel condition respectively.
REQ-035 When there is no transfer, o_vld = 0 and o_eof = 0; o_ch, o_x and o_y hold their values.
REQ-036 Source stalls (sN_vld = 0 while granted) freeze the counters with no timeout; the grant is held until frame completion.
REQ-037 busy = 1 in GNT0 and GNT1.

Reset
REQ-038 rst_n low forces the following values: state IDLE, x = y = 0, pointer favouring source 0, err_sof = 0, o_vld = 0, o_ch = 0, o_x = 0, o_y = 0, o_eof = 0.
REQ-039 While rst_n is low, s0_rdy and s1_rdy are 0 and m_din_vld is 0.
REQ-040 Reset asserted mid-frame abandons the frame; after release, a frame is granted only on a fresh SOF.

Verification
REQ-041 Sim params H_DISP=4, V_DISP=3. Single frame on s0 with continuous valid: 12 transfers, then o_vld runs 12 cycles with o_x 0..3 and o_y 0..2, and o_eof coincides with (3,2).
REQ-042 s0 and s1 assert SOF in the same cycle after reset: s0 is served first and s1 waits with s1_rdy=0. s1 is granted 2 clocks after s0's last transfer, and its windows carry o_ch=1.
REQ-043 Both sources request continuously for 4 frames: the grants alternate 0,1,0,1.
REQ-044 Two non-SOF pixels on s1 in IDLE are consumed with s1_rdy=1, m_din_vld stays 0, and o_vld stays 0.
REQ-045 SOF pulsed on the granted s0 at (2,1): err_sof rises 1 clock later and stays high. The frame still completes after 12 transfers.
REQ-046 A 3-cycle s0_vld gap mid-frame: x/y hold, o_vld=0 for 3 cycles, and no grant switch occurs. Reset pulsed mid-frame: busy=0, and a stray s0 pixel without SOF is discarded.

Source files
------------

// File: rtl/win3x3_frame_arb.sv
// Frame-level arbiter feeding one shared 3x3 window core from two pixel sources.
// A whole frame is granted to one source; window outputs carry source index and position.
module win3x3_frame_arb #(
  parameter logic [11:0] H_DISP = 12'd480,
  parameter logic [11:0] V_DISP = 12'd272
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        s0_vld,
  input  logic        s0_sof,
  input  logic [7:0]  s0_data,
  output logic        s0_rdy,
  input  logic        s1_vld,
  input  logic        s1_sof,
  input  logic [7:0]  s1_data,
  output logic        s1_rdy,
  output logic        m_din_vld,
  output logic [7:0]  m_din,
  output logic        o_vld,
  output logic        o_ch,
  output logic [11:0] o_x,
  output logic [11:0] o_y,
  output logic        o_eof,
  output logic        busy,
  output logic        err_sof
);

  localparam logic [11:0] XMax = H_DISP - 12'd1;
  localparam logic [11:0] YMax = V_DISP - 12'd1;

  typedef enum logic [1:0] {StIdle, StGnt0, StGnt1} state_e;

  state_e      state_q, state_d;
  logic        last_q, last_d;  // source that completed the most recent frame
  logic [11:0] x_q, x_d, y_q, y_d;
  logic        err_q, err_d;
  logic        o_vld_q, o_vld_d, o_ch_q, o_ch_d, o_eof_q, o_eof_d;
  logic [11:0] o_x_q, o_x_d, o_y_q, o_y_d;

  logic gnt_ch, cur_sof, xfer, frame_end, req0, req1;

  always_comb begin
    s0_rdy    = 1'b0;
    s1_rdy    = 1'b0;
    m_din_vld = 1'b0;
    m_din     = 8'd0;
    gnt_ch    = (state_q == StGnt1);
    cur_sof   = 1'b0;
    req0      = s0_vld && s0_sof;
    req1      = s1_vld && s1_sof;

    unique case (state_q)
      StIdle: begin
        // Stray non-SOF pixels are drained; SOF pixels wait for a grant.
        s0_rdy = s0_vld && !s0_sof;
        s1_rdy = s1_vld && !s1_sof;
      end
      StGnt0: begin
        s0_rdy    = 1'b1;
        m_din_vld = s0_vld;
        m_din     = s0_data;
        cur_sof   = s0_sof;
      end
      StGnt1: begin
        s1_rdy    = 1'b1;
        m_din_vld = s1_vld;
        m_din     = s1_data;
        cur_sof   = s1_sof;
      end
      default: ;
    endcase

    if (!rst_n) begin
      s0_rdy = 1'b0;
      s1_rdy = 1'b0;
    end

    xfer      = m_din_vld;
    frame_end = xfer && (x_q == XMax) && (y_q == YMax);

    state_d = state_q;
    last_d  = last_q;
    x_d     = x_q;
    y_d     = y_q;
    err_d   = err_q;

    if (state_q == StIdle) begin
      x_d = 12'd0;
      y_d = 12'd0;
      if (req0 && req1) begin
        state_d = last_q ? StGnt0 : StGnt1;
      end else if (req0) begin
        state_d = StGnt0;
      end else if (req1) begin
        state_d = StGnt1;
      end
    end else if (xfer) begin
      if (cur_sof && ((x_q != 12'd0) || (y_q != 12'd0))) begin
        err_d = 1'b1;
      end
      if (frame_end) begin
        state_d = StIdle;
        last_d  = gnt_ch;
        x_d     = 12'd0;
        y_d     = 12'd0;
      end else if (x_q == XMax) begin
        x_d = 12'd0;
        y_d = y_q + 12'd1;
      end else begin
        x_d = x_q + 12'd1;
      end
    end

    o_vld_d = xfer;
    o_eof_d = frame_end;
    o_ch_d  = o_ch_q;
    o_x_d   = o_x_q;
    o_y_d   = o_y_q;
    if (xfer) begin
      o_ch_d = gnt_ch;
      o_x_d  = x_q;
      o_y_d  = y_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      last_q  <= 1'b1;
      x_q     <= 12'd0;
      y_q     <= 12'd0;
      err_q   <= 1'b0;
      o_vld_q <= 1'b0;
      o_ch_q  <= 1'b0;
      o_x_q   <= 12'd0;
      o_y_q   <= 12'd0;
      o_eof_q <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      x_q     <= x_d;
      y_q     <= y_d;
      err_q   <= err_d;
      o_vld_q <= o_vld_d;
      o_ch_q  <= o_ch_d;
      o_x_q   <= o_x_d;
      o_y_q   <= o_y_d;
      o_eof_q <= o_eof_d;
    end
  end

  assign busy    = (state_q != StIdle);
  assign err_sof = err_q;
  assign o_vld   = o_vld_q;
  assign o_ch    = o_ch_q;
  assign o_x     = o_x_q;
  assign o_y     = o_y_q;
  assign o_eof   = o_eof_q;

endmodule

// File: tb/tb_win3x3_frame_arb.sv
// Scoreboard bench for win3x3_frame_arb: drivers push expected windows on each accepted
// frame pixel, a monitor pops and compares whenever o_vld is presented.
module tb_win3x3_frame_arb;

  localparam int H    = 4;
  localparam int V    = 3;
  localparam int NPIX = H * V;
  localparam int TMO  = 500;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        s0_vld, s0_sof, s1_vld, s1_sof;
  logic [7:0]  s0_data, s1_data;
  logic        s0_rdy, s1_rdy, m_din_vld, o_vld, o_ch, o_eof, busy, err_sof;
  logic [7:0]  m_din;
  logic [11:0] o_x, o_y;

  win3x3_frame_arb #(.H_DISP(12'd4), .V_DISP(12'd3)) dut (
    .clk(clk), .rst_n(rst_n),
    .s0_vld(s0_vld), .s0_sof(s0_sof), .s0_data(s0_data), .s0_rdy(s0_rdy),
    .s1_vld(s1_vld), .s1_sof(s1_sof), .s1_data(s1_data), .s1_rdy(s1_rdy),
    .m_din_vld(m_din_vld), .m_din(m_din),
    .o_vld(o_vld), .o_ch(o_ch), .o_x(o_x), .o_y(o_y), .o_eof(o_eof),
    .busy(busy), .err_sof(err_sof)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic        ch;
    logic [11:0] x;
    logic [11:0] y;
    logic        eof;
  } win_t;

  win_t exp_q[$];
  int   grant_q[$];
  int   kcnt[2];
  int   first_cyc[2];
  int   last_cyc[2];
  int   vectors = 0;
  int   fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic rdy_of(input int n);
    return (n == 1) ? s1_rdy : s0_rdy;
  endfunction

  task automatic set_src(input int n, input logic v, input logic s, input logic [7:0] d);
    if (n == 1) begin
      s1_vld = v; s1_sof = s; s1_data = d;
    end else begin
      s0_vld = v; s0_sof = s; s0_data = d;
    end
  endtask

  task automatic gap(input int g);
    for (int i = 0; i < g; i++) begin
      @(posedge clk); #1;
    end
  endtask

  // Offer one pixel and hold it until accepted; frame pixels add an expected window.
  task automatic drive(input int n, input logic sof, input logic [7:0] d, input bit frame);
    int   t;
    int   k;
    bit   acc;
    win_t w;
    set_src(n, 1'b1, sof, d);
    acc = 1'b0;
    t = 0;
    while (!acc && t < TMO) begin
      @(negedge clk);
      if (rdy_of(n)) begin
        acc = 1'b1;
        if (frame) begin
          chk("fwd_vld", m_din_vld, 1);
          chk("fwd_data", m_din, d);
          k     = kcnt[n];
          w.ch  = n[0];
          w.x   = 12'(k % H);
          w.y   = 12'(k / H);
          w.eof = (k == NPIX - 1);
          exp_q.push_back(w);
          if (k == 0) begin
            first_cyc[n] = cyc;
            grant_q.push_back(n);
          end
          if (k == NPIX - 1) last_cyc[n] = cyc;
          kcnt[n] = (k + 1) % NPIX;
        end else begin
          chk("stray_not_fwd", m_din_vld, 0);
        end
      end
      @(posedge clk); #1;
      t++;
    end
    if (!acc) begin
      vectors++;
      fails++;
      $display("FAIL accept_timeout: source %0d pixel not accepted within %0d cycles", n, TMO);
    end
    set_src(n, 1'b0, 1'b0, 8'd0);
  endtask

  task automatic send_frame(input int n, input int err_idx, input int max_gap,
                            input int strays, input int gap3_at);
    for (int s = 0; s < strays; s++) begin
      drive(n, 1'b0, 8'($urandom), 1'b0);
      gap($urandom_range(0, max_gap));
    end
    for (int k = 0; k < NPIX; k++) begin
      drive(n, (k == 0) || (k == err_idx), 8'($urandom), 1'b1);
      if (err_idx >= 0) chk("err_sof_track", err_sof, (k >= err_idx) ? 1 : 0);
      if (k == gap3_at) gap(3);
      else if (max_gap > 0) gap($urandom_range(0, max_gap));
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    s0_vld = 1'b1; s0_sof = 1'b0; s1_vld = 1'b1; s1_sof = 1'b0;
    #2;
    chk("rst_s0_rdy", s0_rdy, 0);
    chk("rst_s1_rdy", s1_rdy, 0);
    chk("rst_m_din_vld", m_din_vld, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err_sof", err_sof, 0);
    chk("rst_o_vld", o_vld, 0);
    chk("rst_o_ch", o_ch, 0);
    chk("rst_o_x", o_x, 0);
    chk("rst_o_y", o_y, 0);
    chk("rst_o_eof", o_eof, 0);
    s0_vld = 1'b0; s1_vld = 1'b0;
    kcnt[0] = 0; kcnt[1] = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin : monitor
    win_t w;
    forever begin
      @(posedge clk); #1;
      if (rst_n) begin
        if (o_vld) begin
          if (exp_q.size() == 0) begin
            vectors++;
            fails++;
            $display("FAIL spurious_window: o_vld with no expected window ch=%0d x=%0d y=%0d",
                     o_ch, o_x, o_y);
          end else begin
            w = exp_q.pop_front();
            chk("o_ch", o_ch, w.ch);
            chk("o_x", o_x, w.x);
            chk("o_y", o_y, w.y);
            chk("o_eof", o_eof, w.eof);
          end
        end else begin
          chk("o_eof_no_vld", o_eof, 0);
        end
      end
    end
  end

  initial begin
    s0_vld = 0; s0_sof = 0; s0_data = 0;
    s1_vld = 0; s1_sof = 0; s1_data = 0;
    kcnt[0] = 0; kcnt[1] = 0;
    do_reset();

    // Single continuous frame on source 0.
    send_frame(0, -1, 0, 0, -1);
    gap(3);
    chk("single_frame_drained", exp_q.size(), 0);

    // Simultaneous SOF after reset: source 0 first, source 1 two clocks after its end.
    do_reset();
    grant_q.delete();
    fork
      send_frame(0, -1, 0, 0, -1);
      send_frame(1, -1, 0, 0, -1);
    join
    chk("both_grants", grant_q.size(), 2);
    chk("first_grant", grant_q[0], 0);
    chk("second_grant", grant_q[1], 1);
    chk("s1_grant_delay", first_cyc[1] - last_cyc[0], 2);

    // Continuous requests from both: grants alternate.
    grant_q.delete();
    fork
      begin repeat (2) send_frame(0, -1, 0, 0, -1); end
      begin repeat (2) send_frame(1, -1, 0, 0, -1); end
    join
    chk("alt_grants", grant_q.size(), 4);
    chk("alt_g0", grant_q[0], 0);
    chk("alt_g1", grant_q[1], 1);
    chk("alt_g2", grant_q[2], 0);
    chk("alt_g3", grant_q[3], 1);

    // Stray non-SOF pixels on source 1 while idle.
    gap(2);
    drive(1, 1'b0, 8'hA5, 1'b0);
    drive(1, 1'b0, 8'h5A, 1'b0);
    gap(2);
    chk("stray_busy", busy, 0);
    chk("stray_no_window", exp_q.size(), 0);

    // Mid-frame SOF flags an error without restarting the frame.
    chk("err_before", err_sof, 0);
    send_frame(0, 6, 0, 0, -1);
    gap(2);
    chk("err_sticky", err_sof, 1);
    chk("err_frame_drained", exp_q.size(), 0);

    // Three-cycle stall mid-frame.
    send_frame(0, -1, 0, 0, 5);
    gap(2);
    chk("err_still_set", err_sof, 1);

    // Reset mid-frame, then a stray pixel, then a fresh frame.
    for (int k = 0; k < 5; k++) drive(0, k == 0, 8'($urandom), 1'b1);
    gap(2);
    chk("midframe_busy", busy, 1);
    do_reset();
    chk("post_rst_busy", busy, 0);
    chk("post_rst_err", err_sof, 0);
    drive(0, 1'b0, 8'h3C, 1'b0);
    gap(2);
    chk("post_stray_busy", busy, 0);
    send_frame(0, -1, 0, 0, -1);

    // Randomised traffic with stalls and strays on both sources.
    fork
      begin repeat (3) send_frame(0, -1, 2, $urandom_range(0, 2), -1); end
      begin repeat (3) send_frame(1, -1, 2, $urandom_range(0, 2), -1); end
    join
    gap(4);
    chk("final_drained", exp_q.size(), 0);
    chk("final_busy", busy, 0);
    chk("final_err", err_sof, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
